// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package rf_write_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; combinational grants, pointer moves only on a granted (accepted) cycle.
// Grants are qualified by en, so any grant is an accepted handshake.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1
);

    // last_grant = 1 means requester 1 won most recently, so requester 0 wins the next tie
    logic last_grant;

    always_comb begin
        grant0 = en && req0 && (!req1 || last_grant);
        grant1 = en && req1 && (!req0 || !last_grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two register-file write requesters onto one registered write port (1-cycle latency),
// with a full re-zeroing sweep after reset or on clear_req; requesters are held off while sweeping.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clear_req,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic [15:0]       contention_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;
    logic              arb_en;
    logic              grant0;
    logic              grant1;

    assign clr_last = (clr_cnt == {ADDR_W{1'b1}});
    assign arb_en   = (state == RUN) && !clear_req;
    assign busy     = (state == CLEAR);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .req0   (req0_valid),
        .req1   (req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_last) state_nxt = RUN;
            RUN:     if (clear_req) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    // clr_cnt wraps to 0 on the last sweep address, leaving it ready for the next sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt  <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (state == CLEAR) begin
            clr_cnt  <= clr_cnt + 1'b1;
            rf_we    <= 1'b1;
            rf_waddr <= clr_cnt;
            rf_wdata <= '0;
        end else if (grant0) begin
            rf_we    <= (req0_addr != '0);
            rf_waddr <= req0_addr;
            rf_wdata <= req0_data;
        end else if (grant1) begin
            rf_we    <= (req1_addr != '0);
            rf_waddr <= req1_addr;
            rf_wdata <= req1_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contention_cnt <= '0;
        end else if (arb_en && req0_valid && req1_valid && (contention_cnt != 16'hFFFF)) begin
            contention_cnt <= contention_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a cycle-level reference model compared every cycle.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, clear_req;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_we, busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] contention_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    rf_write_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_addr      (req0_addr),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_addr      (req1_addr),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .clear_req      (clear_req),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .busy           (busy),
        .contention_cnt (contention_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sweeping flag + sweep index, who won last, and the expected write port
    bit          m_sweeping;
    int          m_idx;
    int          m_last;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_cnt;

    // Which requester should win right now (-1 = nobody), ignoring sweep/reset
    function automatic int pick();
        if (clear_req) return -1;
        if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sweeping <= 1'b1;
            m_idx      <= 0;
            m_last     <= 1;
            m_we       <= 1'b0;
            m_waddr    <= '0;
            m_wdata    <= '0;
            m_cnt      <= 0;
        end else if (m_sweeping) begin
            m_we    <= 1'b1;
            m_waddr <= 5'(m_idx);
            m_wdata <= '0;
            m_idx   <= (m_idx == 31) ? 0 : m_idx + 1;
            if (m_idx == 31) m_sweeping <= 1'b0;
        end else begin
            if (req0_valid && req1_valid && !clear_req)
                m_cnt <= (m_cnt == 65535) ? 65535 : m_cnt + 1;
            if (clear_req) begin
                m_sweeping <= 1'b1;
                m_we       <= 1'b0;
            end else if (pick() == 0) begin
                m_we <= (req0_addr != 5'd0); m_waddr <= req0_addr; m_wdata <= req0_data; m_last <= 0;
            end else if (pick() == 1) begin
                m_we <= (req1_addr != 5'd0); m_waddr <= req1_addr; m_wdata <= req1_data; m_last <= 1;
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_r0, exp_r1;
        exp_r0 = !rst && !m_sweeping && (pick() == 0);
        exp_r1 = !rst && !m_sweeping && (pick() == 1);
        check("model_we",    64'(rf_we),          64'(m_we));
        check("model_waddr", 64'(rf_waddr),       64'(m_waddr));
        check("model_wdata", 64'(rf_wdata),       64'(m_wdata));
        check("model_busy",  64'(busy),           64'(rst || m_sweeping));
        check("model_rdy0",  64'(req0_ready),     64'(exp_r0));
        check("model_rdy1",  64'(req1_ready),     64'(exp_r1));
        check("model_cnt",   64'(contention_cnt), 64'(m_cnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; clear_req = 0;
        req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        idle_inputs();
        #2;
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_cnt", 64'(contention_cnt), 64'd0);
        repeat (3) step();
        rst = 1'b0;

        // Sweep after reset; requester 0 pushes throughout but must be ignored
        for (int i = 0; i < 32; i++) begin
            step();
            req0_valid = (i < 31); req0_addr = 5'd4; req0_data = 32'h55;
            @(negedge clk);
            check("sweep_we", 64'(rf_we), 64'd1);
            check("sweep_addr", 64'(rf_waddr), 64'(i));
            check("sweep_data", 64'(rf_wdata), 64'd0);
            check("sweep_busy", 64'(busy), (i == 31) ? 64'd0 : 64'd1);
            if (i < 31) check("sweep_rdy0", 64'(req0_ready), 64'd0);
        end

        // Single requester
        step(); idle_inputs();
        req1_valid = 1; req1_addr = 5'd5; req1_data = 32'hDEADBEEF;
        @(negedge clk);
        check("single_rdy1", 64'(req1_ready), 64'd1);
        step(); idle_inputs();
        @(negedge clk);
        check("single_we", 64'(rf_we), 64'd1);
        check("single_addr", 64'(rf_waddr), 64'd5);
        check("single_data", 64'(rf_wdata), 64'hDEADBEEF);

        // Contention: grants alternate 0,1,0,1
        for (int k = 0; k < 5; k++) begin
            step();
            idle_inputs();
            if (k < 4) begin
                req0_valid = 1; req0_addr = 5'd3; req0_data = 32'h100 + k;
                req1_valid = 1; req1_addr = 5'd7; req1_data = 32'h200 + k;
            end
            @(negedge clk);
            if (k < 4) check("cont_rdy0", 64'(req0_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
            if (k >= 1) check("cont_waddr", 64'(rf_waddr), ((k - 1) % 2 == 0) ? 64'd3 : 64'd7);
        end
        check("cont_cnt", 64'(contention_cnt), 64'd4);

        // Write to r0 is consumed but not issued
        step(); idle_inputs();
        req0_valid = 1; req0_addr = 5'd0; req0_data = 32'h1;
        @(negedge clk);
        check("r0_rdy0", 64'(req0_ready), 64'd1);
        step(); idle_inputs();
        @(negedge clk);
        check("r0_we", 64'(rf_we), 64'd0);

        // Clear mid-traffic
        step();
        req0_valid = 1; req0_addr = 5'd9; req0_data = 32'h99;
        @(negedge clk);
        check("clr_rdy0_n", 64'(req0_ready), 64'd1);
        step(); idle_inputs();
        clear_req = 1; req1_valid = 1; req1_addr = 5'd2; req1_data = 32'h22;
        @(negedge clk);
        check("clr_rdy1_n1", 64'(req1_ready), 64'd0);
        check("clr_we_n1", 64'(rf_we), 64'd1);
        check("clr_addr_n1", 64'(rf_waddr), 64'd9);
        step(); idle_inputs();
        @(negedge clk);
        check("clr_busy_n2", 64'(busy), 64'd1);
        check("clr_we_n2", 64'(rf_we), 64'd0);
        for (int i = 0; i < 32; i++) begin
            step();
            clear_req = (i == 5);
            @(negedge clk);
            check("clr_sweep_addr", 64'(rf_waddr), 64'(i));
            check("clr_sweep_we", 64'(rf_we), 64'd1);
        end
        check("clr_sweep_done", 64'(busy), 64'd0);

        // Reset in the middle of a sweep
        step(); clear_req = 1;
        step(); clear_req = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            @(negedge clk);
            if (rf_we && rf_waddr == 5'd12) found = 1;
        end
        check("rst_sweep_reached12", 64'(found), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_we", 64'(rf_we), 64'd0);
        check("rst_mid_addr", 64'(rf_waddr), 64'd0);
        repeat (2) step();
        rst = 1'b0;
        step();
        @(negedge clk);
        check("rst_restart_we", 64'(rf_we), 64'd1);
        check("rst_restart_addr", 64'(rf_waddr), 64'd0);
        repeat (35) step();
        @(negedge clk);
        check("rst_restart_done", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
